// File: rtl/fp_norm_round_pack.sv
// fp_norm_round_pack: back end of the FP add/sub datapath.
// Normalizes one left shift per cycle, rounds to nearest-even and packs an
// IEEE-754 single-precision word behind valid/ready handshakes.
// Optional macro FP_FLUSH_DENORM_EN: flush subnormal results to signed zero.
module fp_norm_round_pack #(
  parameter int MAX_SHIFT = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic        in_sel2,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  input  logic [2:0]  in_grs,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow
);

  localparam int CW = $clog2(MAX_SHIFT + 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t        state, state_next;
  logic          sign_q;
  logic [9:0]    exp_q;      // headroom for carry and round increments past 255
  logic [24:0]   mant_q;
  logic          g_q, r_q, s_q;
  logic [CW-1:0] cnt_q;
  logic          bypass_q;   // special/zero result already packed at capture

  logic accept, is_special, is_zero, can_shift;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid & in_ready;
  assign is_special = (in_exp == 8'hFF);
  assign is_zero    = (in_mant == 25'd0) && (in_grs == 3'd0);
  assign can_shift  = !mant_q[23] && (exp_q > 10'd1) && (int'(cnt_q) < MAX_SHIFT);

  // Round-to-nearest-even and packing of the normalized value.
  logic        inc;
  logic [24:0] sum;
  logic [9:0]  exp_r;
  logic [22:0] frac_r;
  logic [31:0] round_result;
  logic        round_ovf, round_unf;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    exp_r        = 10'd0;
    frac_r       = 23'd0;
    round_result = 32'd0;
    round_ovf    = 1'b0;
    round_unf    = 1'b0;
    inc          = g_q & (r_q | s_q | mant_q[0]);
    sum          = {1'b0, mant_q[23:0]} + {24'd0, inc};
    if (sum[24]) begin
      exp_r  = exp_q + 10'd1;
      frac_r = sum[23:1];
    end else begin
      // A subnormal that rounds up into bit23 keeps exp_q==1, which is the normal field.
      exp_r  = sum[23] ? exp_q : 10'd0;
      frac_r = sum[22:0];
    end
    if (exp_r >= 10'd255) begin
      round_ovf    = 1'b1;
      round_result = {sign_q, 8'hFF, 23'd0};
    end else begin
      round_unf    = (exp_r == 10'd0) && (g_q | r_q | s_q);
      round_result = {sign_q, exp_r[7:0], frac_r};
`ifdef FP_FLUSH_DENORM_EN
      if ((exp_r == 10'd0) && (frac_r != 23'd0)) begin
        round_result = {sign_q, 31'd0};
        round_unf    = 1'b1;
      end
`endif
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = (is_special || is_zero) ? ROUND : NORM;
      NORM:  if (!can_shift) state_next = ROUND;
      ROUND: state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture, iterative normalization, rounding and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q        <= 1'b0;
      exp_q         <= 10'd0;
      mant_q        <= 25'd0;
      g_q           <= 1'b0;
      r_q           <= 1'b0;
      s_q           <= 1'b0;
      cnt_q         <= '0;
      bypass_q      <= 1'b0;
      out_result    <= 32'd0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign_q   <= in_sign;
          cnt_q    <= '0;
          bypass_q <= is_special || is_zero;
          if (is_special) begin
            out_result    <= {in_sign, 8'hFF, in_mant[22:0]};
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
          end else if (is_zero) begin
            out_result    <= {in_sel2 ? 1'b0 : in_sign, 31'd0};
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
          end else if (in_mant[24]) begin
            mant_q <= {1'b0, in_mant[24:1]};
            exp_q  <= {2'b00, in_exp} + 10'd1;
            g_q    <= in_mant[0];
            r_q    <= in_grs[2];
            s_q    <= in_grs[1] | in_grs[0];
          end else begin
            mant_q <= in_mant;
            exp_q  <= {2'b00, in_exp};
            g_q    <= in_grs[2];
            r_q    <= in_grs[1];
            s_q    <= in_grs[0];
          end
        end
        NORM: if (can_shift) begin
          mant_q <= {mant_q[23:0], g_q};
          g_q    <= r_q;
          r_q    <= 1'b0;
          exp_q  <= exp_q - 10'd1;
          cnt_q  <= cnt_q + 1'b1;
        end
        ROUND: if (!bypass_q) begin
          out_result    <= round_result;
          out_overflow  <= round_ovf;
          out_underflow <= round_unf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Directed scoreboard bench for fp_norm_round_pack.
module tb_fp_norm_round_pack;

`ifdef FP_FLUSH_DENORM_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic        in_sel2 = 1'b0;
  logic [7:0]  in_exp = 8'd0;
  logic [24:0] in_mant = 25'd0;
  logic [2:0]  in_grs = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;

  typedef struct {
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  fp_norm_round_pack #(.MAX_SHIFT(24)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_sel2(in_sel2), .in_exp(in_exp),
    .in_mant(in_mant), .in_grs(in_grs),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow),
    .out_underflow(out_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one bundle, wait for the result, compare against the scoreboard,
  // optionally stall out_ready for 'hold' cycles, then accept the result.
  task automatic run_op(input string tag, input logic sign, input logic sel2,
                        input logic [7:0] e, input logic [24:0] m, input logic [2:0] grs,
                        input logic [31:0] res, input logic ovf, input logic unf,
                        input int lat, input int hold);
    exp_t x, got;
    int   n;
    logic [31:0] held;
    x.result = res; x.ovf = ovf; x.unf = unf; x.lat = lat;
    sb.push_back(x);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_sign = sign; in_sel2 = sel2; in_exp = e; in_mant = m; in_grs = grs;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, 32'(out_valid), 32'd1);
      void'(sb.pop_front());
      return;
    end
    got = sb.pop_front();
    check({tag, "_result"},    out_result,           got.result);
    check({tag, "_overflow"},  32'(out_overflow),    32'(got.ovf));
    check({tag, "_underflow"}, 32'(out_underflow),   32'(got.unf));
    check({tag, "_latency"},   32'(n),               32'(got.lat));
    held = out_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"},  32'(out_valid), 32'd1);
      check({tag, "_hold_result"}, out_result,     held);
      check({tag, "_hold_ready"},  32'(in_ready),  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    int seen;
    // Reset state while rst is held.
    #12;
    check("rst_valid",     32'(out_valid),     32'd0);
    check("rst_result",    out_result,         32'd0);
    check("rst_overflow",  32'(out_overflow),  32'd0);
    check("rst_underflow", 32'(out_underflow), 32'd0);
    @(negedge clk); rst = 1'b0;
    check("rst_in_ready",  32'(in_ready),      32'd1);

    run_op("one_plus_one",  1'b0, 1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 1'b0, 1'b0, 2, 0);
    run_op("carry_tie_up",  1'b0, 1'b0, 8'd127, 25'h1000003, 3'b000, 32'h40000002, 1'b0, 1'b0, 2, 0);
    run_op("carry_tie_dn",  1'b0, 1'b0, 8'd127, 25'h1000001, 3'b000, 32'h40000000, 1'b0, 1'b0, 2, 0);
    run_op("one_shift",     1'b1, 1'b1, 8'd127, 25'h0400000, 3'b000, 32'hBF000000, 1'b0, 1'b0, 3, 0);
    run_op("shift_23",      1'b0, 1'b1, 8'd127, 25'h0000001, 3'b000, 32'h34000000, 1'b0, 1'b0, 25, 0);
    run_op("tie_even_up",   1'b0, 1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 1'b0, 1'b0, 2, 0);
    run_op("tie_even_keep", 1'b0, 1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 1'b0, 1'b0, 2, 0);
    run_op("overflow",      1'b0, 1'b0, 8'd254, 25'h1FFFFFF, 3'b000, 32'h7F800000, 1'b1, 1'b0, 2, 0);
    run_op("cancel_zero",   1'b1, 1'b1, 8'd100, 25'h0000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 1, 0);
    run_op("special_nan",   1'b0, 1'b0, 8'hFF,  25'h0C00000, 3'b000, 32'h7FC00000, 1'b0, 1'b0, 1, 0);
    run_op("subnormal",     1'b0, 1'b0, 8'd1,   25'h0400000, 3'b000,
           FLUSH ? 32'h00000000 : 32'h00400000, 1'b0, FLUSH, 2, 0);
    run_op("subnormal_inex",1'b0, 1'b0, 8'd1,   25'h0400000, 3'b011,
           FLUSH ? 32'h00000000 : 32'h00400000, 1'b0, 1'b1, 2, 0);
    run_op("sub_to_normal", 1'b0, 1'b0, 8'd1,   25'h07FFFFF, 3'b100, 32'h00800000, 1'b0, 1'b0, 2, 0);
    run_op("watchdog",      1'b0, 1'b1, 8'd127, 25'h0000000, 3'b001, 32'h00000000, 1'b0, 1'b1, 26, 0);
    run_op("backpressure",  1'b0, 1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 1'b0, 1'b0, 2, 5);

    // Reset in the middle of a long normalization: nothing may be emitted.
    @(negedge clk);
    in_sign = 1'b0; in_sel2 = 1'b1; in_exp = 8'd127; in_mant = 25'h0000001; in_grs = 3'b000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid",     32'(out_valid),     32'd0);
    check("midrst_result",    out_result,         32'd0);
    check("midrst_underflow", 32'(out_underflow), 32'd0);
    check("midrst_in_ready",  32'(in_ready),      32'd1);
    @(negedge clk); rst = 1'b0;
    #1;
    check("midrst_ready_rel", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_emit", 32'(seen), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_norm_round_pack.md
Name: fp_norm_round_pack

Overview:
- Back end of the FP adder/subtractor datapath. Consumes the result sign and effective-operation bit from the sign stage, plus the raw mantissa sum/difference, exponent and guard/round/sticky bits.
- Normalizes iteratively, one left shift per cycle; the carry case is handled at capture.
- Rounds to nearest-even and packs an IEEE-754 single-precision word.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- MAX_SHIFT, 24, cap on NORM-state left shifts; a watchdog that forces ROUND when reached.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_sign  in  1  result sign from sign stage.
- in_sel2  in  1  effective subtract (magnitudes differ in sign).
- in_exp  in  8  biased exponent of the larger operand.
- in_mant  in  25  bit24 carry, bit23 hidden, [22:0] fraction.
- in_grs  in  3  guard, round, sticky from the alignment shift.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts.
- out_result  out  32  {sign, exp[7:0], frac[22:0]}.
- out_overflow  out  1  result rounded/normalized to infinity.
- out_underflow  out  1  subnormal/zero result that was inexact, or flushed.

Behaviour:
- Reset (async, any state):
  - state=IDLE, in_ready=1 after release.
  - out_valid=0, out_result=0, out_overflow=0, out_underflow=0.
  - All internal registers cleared.
- States: IDLE -> NORM -> ROUND -> DONE -> IDLE.
- Accept is in_valid & in_ready at edge T0. Capture actions:
  - Special: in_exp==8'hFF -> bypass to DONE at T0+1 with out_result={in_sign,8'hFF,in_mant[22:0]}; flags 0.
  - Zero: in_mant==0 and in_grs==0 -> DONE at T0+1, out_result = {in_sel2 ? 1'b0 : in_sign, 31'b0}.
  - Carry: in_mant[24]==1 -> shift right 1, exp+1, new G=mant[0], R=old G, S=old R|S. Go NORM.
  - Otherwise load registers unchanged and go NORM.
- NORM, each edge:
  - If mant[23]==0 and exp>1 and shift count<MAX_SHIFT: shift left 1, G enters bit0, R->G, S holds, exp-1.
  - Else go ROUND.
  - k left shifts take k+1 edges.
- Subnormal: if NORM exits with mant[23]==0 (exp==1), the packed exponent field is 0.
- ROUND (1 edge):
  - inc = G & (R | S | mant[0]); mant += inc.
  - If the increment carries into bit24, or turns a subnormal into normal, adjust exp/field accordingly (+1).
  - If exp>=255 after carry/round -> {sign, 8'hFF, 23'b0}, out_overflow=1.
  - out_underflow=1 iff the packed exponent field is 0 and (G|R|S) was nonzero before rounding.
  - Go DONE.
- DONE:
  - out_valid=1; out_result and flags stable while out_ready=0.
  - On out_ready: out_valid=0 next edge, go IDLE.
  - No same-cycle re-accept.
- Latency: out_valid rises at edge T0+k+2 (k=0 for carry or already normalized); special/zero cases take T0+1.
- in_* inputs are ignored outside IDLE. out_ready is ignored outside DONE.
- Reset mid-operation aborts the in-flight result; nothing is emitted.

Optional Feature:
- FP_FLUSH_DENORM_EN defined:
  - Any result whose packed exponent field would be 0 and mantissa nonzero becomes {sign, 31'b0}.
  - out_underflow=1.
  - The NORM exit condition is unchanged.
- Undefined: gradual subnormals as described above.

Test Plan:
- 1.0+1.0: in_sign=0, in_sel2=0, in_exp=127, in_mant=25'h1000000, in_grs=0 -> out_result=32'h40000000, flags 0, out_valid at T0+2.
- 1.5-1.0: in_sel2=1, in_exp=127, in_mant=25'h0400000 -> one shift, 32'h3F000000 at T0+3. Also in_mant=25'h0000001, in_exp=127 -> 23 shifts, 32'h34000000 at T0+25.
- Tie to even:
  - in_exp=127, in_mant=25'h0800001, in_grs=3'b100 -> 32'h3F800002.
  - Same with in_mant=25'h0800000 -> 32'h3F800000.
- Overflow: in_exp=254, in_mant=25'h1FFFFFF, in_grs=0 -> 32'h7F800000, out_overflow=1.
- Cancellation/special:
  - in_sel2=1, in_sign=1, in_mant=0, in_grs=0 -> 32'h00000000 at T0+1.
  - in_exp=8'hFF, in_mant=25'h0C00000 -> 32'h7FC00000.
- Subnormal/backpressure/reset:
  - in_exp=1, in_mant=25'h0400000 -> 32'h00400000, underflow 0 (macro defined: 32'h00000000, underflow 1).
  - Hold out_ready=0 for 5 cycles -> result stable, in_ready=0.
  - Assert rst during NORM -> outputs 0 immediately, in_ready=1 after release.
